// File: rtl/sdp_frame_reader.sv
// rtl/sdp_frame_reader.sv - read-side frame streaming engine for the SDP frame buffer
//
// Accepts {start word address, byte length} descriptors, drives the RAM read
// port and streams the frame as 32-bit AXI-Stream. Backpressure gates the RAM
// read enable, so the RAM output register serves as the stream output stage.
// Optional feature macro: SDP_RD_BYTE_SWAP_EN (RAM words stored in network order).
//
// Ports:
//   rd_clk, rd_sreset             clock, synchronous active-high reset
//   desc_valid/ready/addr/len     descriptor handshake
//   ram_rd_addr, ram_rd_allow     RAM read address (registered) and read enable
//   ram_data_out                  RAM read data (one cycle after an enabled read)
//   m_axis_t*                     output stream
//   free_valid, free_words        pulse and word count when a frame is consumed
//   desc_err                      pulse when a descriptor is rejected
module sdp_frame_reader #(
  parameter int ADDR_WIDTH = 9,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_sreset,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [ADDR_WIDTH-1:0] desc_addr,
  input  logic [LEN_WIDTH-1:0]  desc_len,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                  ram_rd_allow,
  input  logic [31:0]           ram_data_out,
  output logic [31:0]           m_axis_tdata,
  output logic [3:0]            m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  free_valid,
  output logic [LEN_WIDTH-2:0]  free_words,
  output logic                  desc_err
);

  localparam int WW = LEN_WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_STREAM
  } state_t;

  state_t                state;
  state_t                state_next;

  logic [LEN_WIDTH:0]    len_plus3;
  logic [WW-1:0]         desc_words;
  logic [31:0]           words_ext;
  logic                  desc_bad;
  logic                  desc_fire;
  logic                  beat_fire;
  logic                  last_fire;
  logic [3:0]            keep_sel;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WW-1:0]         issue_left;
  logic [WW-1:0]         beat_left;
  logic [WW-1:0]         words_q;
  logic [3:0]            last_keep;
  logic                  tvalid_q;

  // ceil(len/4) without losing the carry out of the top bit
  assign len_plus3  = {1'b0, desc_len} + {{(LEN_WIDTH-1){1'b0}}, 2'd3};
  assign desc_words = len_plus3[LEN_WIDTH:2];
  assign words_ext  = 32'(desc_words);
  assign desc_bad   = (desc_len == '0) || (words_ext > (32'd1 << ADDR_WIDTH));

  // desc_ready is forced low while reset is held, even if state is already IDLE
  assign desc_ready = (state == S_IDLE) && !rd_sreset;
  assign desc_fire  = desc_valid && desc_ready;
  assign beat_fire  = tvalid_q && m_axis_tready;
  assign last_fire  = beat_fire && m_axis_tlast;

  assign ram_rd_addr   = addr_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tvalid_q && (beat_left == WW'(1));
  assign m_axis_tkeep  = m_axis_tlast ? last_keep : 4'hF;

`ifdef SDP_RD_BYTE_SWAP_EN
  assign m_axis_tdata = {ram_data_out[7:0], ram_data_out[15:8],
                         ram_data_out[23:16], ram_data_out[31:24]};
`else
  assign m_axis_tdata = ram_data_out;
`endif

  always_comb begin
    keep_sel = 4'hF;
    case (desc_len[1:0])
      2'd1:    keep_sel = 4'h1;
      2'd2:    keep_sel = 4'h3;
      2'd3:    keep_sel = 4'h7;
      default: keep_sel = 4'hF;
    endcase
  end

  always_comb begin
    state_next   = state;
    ram_rd_allow = 1'b0;
    case (state)
      S_IDLE: begin
        if (desc_fire && !desc_bad) state_next = S_PRIME;
      end
      S_PRIME: begin
        ram_rd_allow = 1'b1;
        state_next   = S_STREAM;
      end
      S_STREAM: begin
        // refill only when the output register is empty or draining this cycle
        ram_rd_allow = (issue_left != '0) && (!tvalid_q || m_axis_tready);
        if (last_fire) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_sreset) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      issue_left <= '0;
      beat_left  <= '0;
      words_q    <= '0;
      last_keep  <= 4'hF;
      tvalid_q   <= 1'b0;
      free_valid <= 1'b0;
      free_words <= '0;
      desc_err   <= 1'b0;
    end else begin
      state      <= state_next;
      free_valid <= 1'b0;
      desc_err   <= 1'b0;

      if (state == S_IDLE && desc_fire) begin
        if (desc_bad) begin
          desc_err <= 1'b1;
        end else begin
          addr_q     <= desc_addr;
          issue_left <= desc_words;
          beat_left  <= desc_words;
          words_q    <= desc_words;
          last_keep  <= keep_sel;
        end
      end

      if (ram_rd_allow) begin
        addr_q     <= addr_q + ADDR_WIDTH'(1);
        issue_left <= issue_left - WW'(1);
      end

      // a read always lands in the output register next cycle; a handshake
      // with no read behind it empties the register
      if (ram_rd_allow) begin
        tvalid_q <= 1'b1;
      end else if (beat_fire) begin
        tvalid_q <= 1'b0;
      end

      if (beat_fire) beat_left <= beat_left - WW'(1);

      if (last_fire) begin
        free_valid <= 1'b1;
        free_words <= words_q;
      end
    end
  end

endmodule

// File: tb/tb_sdp_frame_reader.sv
// tb/tb_sdp_frame_reader.sv - self-checking bench for sdp_frame_reader
module tb_sdp_frame_reader;

  localparam int AW = 9;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rd_sreset;
  logic          desc_valid;
  logic          desc_ready;
  logic [AW-1:0] desc_addr;
  logic [LW-1:0] desc_len;
  logic [AW-1:0] ram_rd_addr;
  logic          ram_rd_allow;
  logic [31:0]   ram_data_out;
  logic [31:0]   m_axis_tdata;
  logic [3:0]    m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          free_valid;
  logic [LW-2:0] free_words;
  logic          desc_err;

  logic [31:0]   mem [0:511];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sdp_frame_reader #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .rd_clk        (clk),
    .rd_sreset     (rd_sreset),
    .desc_valid    (desc_valid),
    .desc_ready    (desc_ready),
    .desc_addr     (desc_addr),
    .desc_len      (desc_len),
    .ram_rd_addr   (ram_rd_addr),
    .ram_rd_allow  (ram_rd_allow),
    .ram_data_out  (ram_data_out),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .free_valid    (free_valid),
    .free_words    (free_words),
    .desc_err      (desc_err)
  );

  // simple-dual-port RAM read side: output register with sync reset and hold
  always_ff @(posedge clk) begin
    if (rd_sreset) ram_data_out <= 32'h0;
    else if (ram_rd_allow) ram_data_out <= mem[ram_rd_addr];
  end

  function automatic logic [31:0] ram_pat(input int a);
    return 32'hA500_0000 | (32'(a) << 12) | 32'(a);
  endfunction

  function automatic logic [31:0] exp_data(input int a);
    logic [31:0] w;
    w = ram_pat(a);
`ifdef SDP_RD_BYTE_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // mode 0: sink always ready; mode 1: ready pattern 1,0,0 repeating over valid cycles
  task automatic do_frame(input int a, input int len, input int words, input logic [3:0] lkeep,
                          input int mode, input bit chk_lat);
    int  cyc;
    int  beat;
    int  lat;
    int  phase;
    bit  first;
    @(negedge clk);
    desc_addr  = AW'(a);
    desc_len   = LW'(len);
    desc_valid = 1'b1;
    #1;
    cyc = 0;
    while (!desc_ready && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    check("desc_ready", 32'(desc_ready), 32'd1);
    @(negedge clk);
    desc_valid = 1'b0;
    beat = 0; lat = 1; phase = 0; first = 1'b1; cyc = 0;
    while (beat < words && cyc < 2000) begin
      m_axis_tready = (mode == 0) ? 1'b1 : ((phase % 3) == 0);
      #1;
      if (m_axis_tvalid) begin
        if (first && chk_lat) check("latency", 32'(lat), 32'd2);
        first = 1'b0;
        phase++;
        if (m_axis_tready) begin
          check("tdata", m_axis_tdata, exp_data((a + beat) % 512));
          check("tkeep", 32'(m_axis_tkeep), (beat == words - 1) ? 32'(lkeep) : 32'hF);
          check("tlast", 32'(m_axis_tlast), (beat == words - 1) ? 32'd1 : 32'd0);
          beat++;
        end else begin
          check("stall_allow", 32'(ram_rd_allow), 32'd0);
          check("stall_data", m_axis_tdata, exp_data((a + beat) % 512));
        end
      end
      @(negedge clk);
      cyc++; lat++;
    end
    check("beat_count", 32'(beat), 32'(words));
    #1;
    check("free_valid", 32'(free_valid), 32'd1);
    check("free_words", 32'(free_words), 32'(words));
    check("tvalid_after", 32'(m_axis_tvalid), 32'd0);
    m_axis_tready = 1'b1;
  endtask

  task automatic do_reject(input int len);
    bit seen_v;
    bit seen_f;
    bit seen_e;
    bit seen_r;
    @(negedge clk);
    desc_addr  = AW'(32'h020);
    desc_len   = LW'(len);
    desc_valid = 1'b1;
    #1;
    check("rej_ready", 32'(desc_ready), 32'd1);
    @(negedge clk);
    desc_valid = 1'b0;
    #1;
    check("rej_err", 32'(desc_err), 32'd1);
    seen_v = m_axis_tvalid; seen_f = free_valid; seen_e = 1'b0; seen_r = ram_rd_allow;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      seen_v |= m_axis_tvalid;
      seen_f |= free_valid;
      seen_e |= desc_err;
      seen_r |= ram_rd_allow;
    end
    check("rej_tvalid", 32'(seen_v), 32'd0);
    check("rej_free", 32'(seen_f), 32'd0);
    check("rej_err_once", 32'(seen_e), 32'd0);
    check("rej_allow", 32'(seen_r), 32'd0);
    check("rej_ready_back", 32'(desc_ready), 32'd1);
  endtask

  typedef struct {
    int         addr;
    int         len;
    int         words;
    logic [3:0] keep;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int          hs;
    bit          pend;
    int          nb;
    logic [3:0]  bk [8];
    logic        bl [8];
    logic [31:0] bd [8];
    int          bc [8];
    bit          seen_v;
    bit          seen_f;

    vecs[0] = '{32'h010, 10, 3, 4'h3};
    vecs[1] = '{32'h020, 4, 1, 4'hF};
    vecs[2] = '{32'h030, 5, 2, 4'h1};
    vecs[3] = '{32'h040, 7, 2, 4'h7};
    vecs[4] = '{32'h1FE, 16, 4, 4'hF};
    vecs[5] = '{32'h000, 1, 1, 4'h1};
    vecs[6] = '{32'h1F0, 2048, 512, 4'hF};

    for (int i = 0; i < 512; i++) mem[i] = ram_pat(i);

    rd_sreset     = 1'b1;
    desc_valid    = 1'b0;
    desc_addr     = '0;
    desc_len      = '0;
    m_axis_tready = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 32'(desc_ready), 32'd0);
    check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_allow", 32'(ram_rd_allow), 32'd0);
    check("rst_tlast", 32'(m_axis_tlast), 32'd0);
    check("rst_free", 32'(free_valid), 32'd0);
    check("rst_err", 32'(desc_err), 32'd0);
    check("rst_addr", 32'(ram_rd_addr), 32'd0);
    check("rst_words", 32'(free_words), 32'd0);
    check("rst_tdata", m_axis_tdata, 32'd0);
    rd_sreset = 1'b0;
    @(negedge clk); #1;
    check("ready_after_rst", 32'(desc_ready), 32'd1);

    for (int i = 0; i < 7; i++)
      do_frame(vecs[i].addr, vecs[i].len, vecs[i].words, vecs[i].keep, 0, 1'b1);

    do_frame(32'h0C0, 16, 4, 4'hF, 1, 1'b1);
    do_frame(32'h1FD, 11, 3, 4'h7, 1, 1'b0);

    do_reject(0);
    do_reject(2049);

    // back-to-back: descriptor valid held, second descriptor presented right after the first is taken
    @(negedge clk);
    desc_addr = AW'(32'h080); desc_len = LW'(4); desc_valid = 1'b1; m_axis_tready = 1'b1;
    hs = 0; pend = 1'b0; nb = 0;
    for (int c = 0; c < 16; c++) begin
      if (c != 0) @(negedge clk);
      if (pend) begin
        hs++;
        if (hs == 1) begin
          desc_addr = AW'(32'h090); desc_len = LW'(5);
        end else begin
          desc_valid = 1'b0;
        end
      end
      #1;
      if (m_axis_tvalid && nb < 8) begin
        bk[nb] = m_axis_tkeep; bl[nb] = m_axis_tlast; bd[nb] = m_axis_tdata; bc[nb] = c;
        nb++;
      end
      pend = desc_valid && desc_ready;
    end
    check("b2b_beats", 32'(nb), 32'd3);
    if (nb >= 3) begin
      check("b2b_keep0", 32'(bk[0]), 32'hF);
      check("b2b_last0", 32'(bl[0]), 32'd1);
      check("b2b_data0", bd[0], exp_data(32'h080));
      check("b2b_keep1", 32'(bk[1]), 32'hF);
      check("b2b_last1", 32'(bl[1]), 32'd0);
      check("b2b_data1", bd[1], exp_data(32'h090));
      check("b2b_keep2", 32'(bk[2]), 32'h1);
      check("b2b_last2", 32'(bl[2]), 32'd1);
      check("b2b_data2", bd[2], exp_data(32'h091));
      check("b2b_gap", 32'(bc[1] - bc[0]), 32'd3);
      check("b2b_spacing", 32'(bc[2] - bc[1]), 32'd1);
    end

    // reset on beat 2 of a 4-beat frame
    @(negedge clk);
    desc_addr = AW'(32'h0A0); desc_len = LW'(16); desc_valid = 1'b1; m_axis_tready = 1'b1;
    #1;
    check("mr_ready", 32'(desc_ready), 32'd1);
    @(negedge clk);
    desc_valid = 1'b0;
    @(negedge clk); #1;
    check("mr_beat1", m_axis_tdata, exp_data(32'h0A0));
    @(negedge clk); #1;
    check("mr_beat2_valid", 32'(m_axis_tvalid), 32'd1);
    check("mr_beat2", m_axis_tdata, exp_data(32'h0A1));
    rd_sreset = 1'b1;
    @(negedge clk); #1;
    check("mr_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("mr_allow", 32'(ram_rd_allow), 32'd0);
    check("mr_tlast", 32'(m_axis_tlast), 32'd0);
    check("mr_tdata", m_axis_tdata, 32'd0);
    check("mr_addr", 32'(ram_rd_addr), 32'd0);
    check("mr_free", 32'(free_valid), 32'd0);
    check("mr_ready_low", 32'(desc_ready), 32'd0);
    rd_sreset = 1'b0;
    @(negedge clk); #1;
    check("mr_ready_back", 32'(desc_ready), 32'd1);
    seen_v = m_axis_tvalid; seen_f = free_valid;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      seen_v |= m_axis_tvalid;
      seen_f |= free_valid;
    end
    check("mr_no_tvalid", 32'(seen_v), 32'd0);
    check("mr_no_free", 32'(seen_f), 32'd0);
    do_frame(32'h0B0, 8, 2, 4'hF, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdp_frame_reader.md
# sdp_frame_reader

Read-side engine for the Ethernet frame buffer. It accepts frame descriptors (start address and byte length), drives the read port of the simple-dual-port RAM, and streams each frame out as 32-bit AXI-Stream with full backpressure. Backpressure is absorbed by gating the RAM read enable, so the RAM output register doubles as the output stage. On completion it returns the consumed word count so the write side can reclaim buffer space.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 9: RAM word-address width. RAM depth is 2^ADDR_WIDTH words.
- `LEN_WIDTH`, default 16: descriptor byte-length width.

**Ports**
- `rd_clk`  in  1: sole clock.
- `rd_sreset`  in  1: reset, synchronous, active-high. The same net also drives the RAM `rd_sreset`.
- `desc_valid`  in  1: descriptor offered.
- `desc_ready`  out  1: descriptor accepted when high together with `desc_valid`.
- `desc_addr`  in  ADDR_WIDTH: word address of frame byte 0.
- `desc_len`  in  LEN_WIDTH: frame length in bytes.
- `ram_rd_addr`  out  ADDR_WIDTH: RAM read address (registered).
- `ram_rd_allow`  out  1: RAM read enable. Low holds the RAM output register.
- `ram_data_out`  in  32: RAM read data, valid one cycle after an enabled read.
- `m_axis_tdata`  out  32: frame data. Frame byte n%4 is in lane n%4; lane 0 is [7:0].
- `m_axis_tkeep`  out  4: byte enables.
- `m_axis_tvalid`  out  1: output beat valid.
- `m_axis_tready`  in  1: sink ready.
- `m_axis_tlast`  out  1: last beat of the frame.
- `free_valid`  out  1: one-cycle pulse when a frame has been fully consumed.
- `free_words`  out  LEN_WIDTH-1: words released; valid while `free_valid` is high.
- `desc_err`  out  1: one-cycle pulse when a descriptor is rejected.

## Operation

**Word count:** words = ceil(`desc_len`/4), computed as (`desc_len` + 3) >> 2.

**States**

*IDLE*
- `desc_ready` = 1.
- On handshake, latch the address and the word count into both `issue_left` and `beat_left`, then go to PRIME.
- If `desc_len` = 0 or words > 2^ADDR_WIDTH: pulse `desc_err` and stay in IDLE. The frame is not streamed and `free_valid` does not pulse.

*PRIME*
- Issue the first read: `ram_rd_allow` = 1, address = latched start address.
- Decrement `issue_left`, increment the address, go to STREAM.

*STREAM*
- `ram_rd_allow` = (`issue_left` ≠ 0) & (!`m_axis_tvalid` | `m_axis_tready`).
- On each enabled read: increment the address modulo 2^ADDR_WIDTH and decrement `issue_left`.
- `m_axis_tvalid` is set the cycle after an enabled read. It clears after a handshake that has no new read behind it.
- On each handshake, decrement `beat_left`.
- `m_axis_tlast` is high on the beat where `beat_left` = 1.
- On the tlast handshake: pulse `free_valid` with `free_words` = word count, and return to IDLE.

**tkeep:**
- Non-last beats: 4'hF.
- Last beat, by `desc_len`[1:0]: 0 → 4'hF, 1 → 4'h1, 2 → 4'h3, 3 → 4'h7.
- Data bytes outside `m_axis_tkeep` are don't-care.

**Address wrap:** reads past address 2^ADDR_WIDTH−1 continue from 0.

**Stall:**
- While `m_axis_tvalid` & !`m_axis_tready`, `ram_rd_allow` = 0.
- `m_axis_tdata`, `m_axis_tkeep` and `m_axis_tlast` hold stable.

## Timing

**Reset values:** `desc_ready` 0 during reset, 1 in the cycle after. `ram_rd_allow`, `m_axis_tvalid`, `m_axis_tlast`, `free_valid` and `desc_err` are 0. `ram_rd_addr` and `free_words` are 0. `m_axis_tdata` is 0, through the RAM's synchronous reset.

**Latency:** descriptor handshake at cycle T → first read issued at T+1 → first `m_axis_tvalid` at T+2.

**Throughput:** with `m_axis_tready` held high, one beat per cycle.

**Inter-frame gap:** tlast handshake at cycle L → IDLE at L+1 (may accept a descriptor) → next first beat no earlier than L+3.

**Reset mid-frame:** the frame is abandoned. No `free_valid`. The state is IDLE the cycle after reset deasserts.

**Simultaneous handshake and refill:** a handshake in the same cycle as an enabled read keeps `m_axis_tvalid` high with the new data.

## Configuration

**`SDP_RD_BYTE_SWAP_EN`**
- Defined: the buffer stores frames in network order, with byte 0 at RAM bits [31:24]. The reader reverses the bytes of each word, so `m_axis_tdata`[7:0] = `ram_data_out`[31:24]. `m_axis_tkeep` is unchanged.
- Undefined: `m_axis_tdata` = `ram_data_out` directly.

## Test plan

- **Single frame, sink always ready:** addr 0x010, len 10 → 3 beats with tkeep F, F, 3. tlast on beat 3. First tvalid 2 cycles after the descriptor handshake. `free_valid` pulse with `free_words` = 3.
- **Backpressure:** len 16 with `m_axis_tready` toggling 1,0,0,1,… → 4 beats in order, with no duplicates or drops. `ram_rd_allow` = 0 and data stable during every stall.
- **Wrap:** addr 2^ADDR_WIDTH−2, len 16 → reads at addresses 510, 511, 0, 1 (ADDR_WIDTH = 9). Data matches the preloaded RAM contents.
- **Rejects:** len 0 → `desc_err` pulse, no tvalid, no `free_valid`. Len 2049 (more than 512 words at ADDR_WIDTH = 9) → same.
- **Back-to-back frames:** len 4 then len 5 offered continuously → beats F/tlast, then F, 1/tlast. Exactly 2 cycles of tvalid low between the frames.
- **Mid-frame reset:** `rd_sreset` asserted on beat 2 of 4 → outputs at reset values the next cycle, no `free_valid`. A new descriptor afterwards streams correctly.
